bus_arbiter_2to1: RTL and testbench

//   Shares one 16-bit datapath bus between two requesters, X and Y.

---
 rtl/arb_pkg.sv | 38 +++
 rtl/bus_arbiter_2to1_mux.sv | 17 +
 rtl/bus_arbiter_2to1.sv | 136 +++++++++++++
 tb/tb_bus_arbiter_2to1.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 2:1 bus arbiter.
// Holds the FSM state encoding, the requester-side type used for the
// round-robin pointer and the idle arbitration helper.
package arb_pkg;

  // Arbiter FSM states. Values are fixed so debug taps can decode them.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_X = 2'd1,
    GNT_Y = 2'd2
  } arb_state_t;

  // Which requester was granted most recently (round-robin pointer).
  typedef enum logic {
    SIDE_Y = 1'b0,
    SIDE_X = 1'b1
  } side_t;

  localparam int BUS_W = 16;

  // Decision taken from IDLE: a lone requester wins outright, a tie goes to
  // the side that was not served last, and no request keeps the bus idle.
  function automatic arb_state_t pick_idle(input logic  rx,
                                           input logic  ry,
                                           input side_t last);
    arb_state_t nxt;
    nxt = IDLE;
    if (rx && ry) begin
      nxt = (last == SIDE_X) ? GNT_Y : GNT_X;
    end else if (rx) begin
      nxt = GNT_X;
    end else if (ry) begin
      nxt = GNT_Y;
    end
    return nxt;
  endfunction

endpackage : arb_pkg

// File: rtl/bus_arbiter_2to1_mux.sv
// 2:1 datapath mux feeding the shared bus.
// s = 1 selects x, s = 0 selects y. Purely combinational.
module bus_arbiter_2to1_mux
  import arb_pkg::*;
#(
  parameter int WIDTH = BUS_W
) (
  input  logic             s,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] m
);

  // Select the granted requester's payload.
  assign m = s ? x : y;

endmodule : bus_arbiter_2to1_mux

// File: rtl/bus_arbiter_2to1.sv
// Round-robin arbiter sharing one bus between requesters X and Y.
//
// Optional feature, compile macro ARB_HOLD_TIMEOUT_EN:
//   defined   - an owner is forced off the bus after MAX_HOLD grant cycles
//               when the other side is waiting.
//   undefined - no hold counter; an owner keeps the bus until it drops its
//               request.
//
// Handshake: a requester raises req_* and holds it (with stable data) for the
// whole transfer. A request sampled at edge N yields grant_* after edge N+1's
// predecessor, i.e. the grant is visible from the very next clock edge, and
// the grant lasts as long as the request stays high (subject to the timeout).
// bus_valid qualifies bus; bus carries the data of the granted side.
module bus_arbiter_2to1
  import arb_pkg::*;
#(
  parameter int WIDTH    = BUS_W,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_x,
  input  logic             req_y,
  input  logic [WIDTH-1:0] x_data,
  input  logic [WIDTH-1:0] y_data,
  output logic             grant_x,
  output logic             grant_y,
  output logic             sel,
  output logic [WIDTH-1:0] bus,
  output logic             bus_valid,
  output logic [1:0]       dbg_state
);

  // MAX_HOLD must allow at least one grant cycle.
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("bus_arbiter_2to1: MAX_HOLD must be >= 1");
  end

  arb_state_t state;
  arb_state_t state_next;
  side_t      last_served;
  logic       entering;
  logic       hold_expired;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt;

  // The counter saturates at MAX_HOLD when nobody is waiting, so the limit is
  // treated as reached from MAX_HOLD-1 upward; a late competing request still
  // forces the hand-over instead of being starved.
  assign hold_expired = (hold_cnt >= HOLD_LAST);

  // Count consecutive cycles of the current grant; restart on each new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (entering) begin
      hold_cnt <= '0;
    end else if ((state != IDLE) && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  // Without the timeout an owner is never forced off the bus.
  assign hold_expired = 1'b0;
`endif

  // Next-state decision: idle arbitration, hold while requested, hand over
  // directly to a waiting requester without an idle bubble.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        state_next = pick_idle(req_x, req_y, last_served);
      end
      GNT_X: begin
        if (!req_x) begin
          state_next = req_y ? GNT_Y : IDLE;
        end else if (req_y && hold_expired) begin
          state_next = GNT_Y;
        end
      end
      GNT_Y: begin
        if (!req_y) begin
          state_next = req_x ? GNT_X : IDLE;
        end else if (req_x && hold_expired) begin
          state_next = GNT_X;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A new grant starts whenever the next state is a grant state different
  // from the current one.
  assign entering = (state_next != state) && (state_next != IDLE);

  // State register plus the select and round-robin pointer, both of which
  // change only when a new grant begins; sel holds its value through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= 1'b0;
      last_served <= SIDE_Y;
    end else begin
      state <= state_next;
      if (entering) begin
        sel         <= (state_next == GNT_X);
        last_served <= (state_next == GNT_X) ? SIDE_X : SIDE_Y;
      end
    end
  end

  // Grants decode straight from the state register, so they are glitch-free
  // and mutually exclusive by construction.
  assign grant_x   = (state == GNT_X);
  assign grant_y   = (state == GNT_Y);
  assign bus_valid = grant_x | grant_y;
  assign dbg_state = state;

  bus_arbiter_2to1_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .s (sel),
    .x (x_data),
    .y (y_data),
    .m (bus)
  );

endmodule : bus_arbiter_2to1

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1: directed scenarios followed by a
// randomized run, all checked against a rule-level reference model.
module tb_bus_arbiter_2to1;

  localparam int W     = 16;
  localparam int MH    = 4;
  localparam int OUT_W = W + 4;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         req_x;
  logic         req_y;
  logic [W-1:0] x_data;
  logic [W-1:0] y_data;
  logic         grant_x;
  logic         grant_y;
  logic         sel;
  logic [W-1:0] bus;
  logic         bus_valid;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  bus_arbiter_2to1 #(
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_x     (req_x),
    .req_y     (req_y),
    .x_data    (x_data),
    .y_data    (y_data),
    .grant_x   (grant_x),
    .grant_y   (grant_y),
    .sel       (sel),
    .bus       (bus),
    .bus_valid (bus_valid),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];

  // Reference model: owner 0 = nobody, 1 = X, 2 = Y.
  int m_own  = 0;
  int m_last = 2;
  int m_held = 0;
  bit m_sel  = 1'b0;
  bit prev_gx = 1'b0;
  bit prev_gy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the arbitration rules to the inputs about to be sampled.
  task automatic model_step();
    int nxt;
    bit forced;
    if (rst) begin
      m_own  = 0;
      m_last = 2;
      m_held = 0;
      m_sel  = 1'b0;
    end else begin
      nxt    = m_own;
      forced = TO_EN && (m_held >= MH - 1);
      if (m_own == 0) begin
        if (req_x && req_y) nxt = (m_last == 1) ? 2 : 1;
        else if (req_x)     nxt = 1;
        else if (req_y)     nxt = 2;
      end else if (m_own == 1) begin
        if (!req_x)                nxt = req_y ? 2 : 0;
        else if (req_y && forced)  nxt = 2;
      end else begin
        if (!req_y)                nxt = req_x ? 1 : 0;
        else if (req_x && forced)  nxt = 1;
      end
      if (nxt != 0 && nxt != m_own) begin
        m_sel  = (nxt == 1);
        m_last = nxt;
        m_held = 0;
      end else if (nxt != 0) begin
        m_held = (m_held + 1 > MH) ? MH : m_held + 1;
      end
      m_own = nxt;
    end
    exp_q.push_back({(m_own == 1), (m_own == 2), m_sel, (m_own != 0),
                     (m_sel ? x_data : y_data)});
  endtask

  task automatic check_outputs();
    logic [OUT_W-1:0] e;
    e = exp_q.pop_front();
    chk("grant_x",   grant_x,   e[W+3]);
    chk("grant_y",   grant_y,   e[W+2]);
    chk("sel",       sel,       e[W+1]);
    chk("bus_valid", bus_valid, e[W]);
    chk("bus",       bus,       e[W-1:0]);
    chk("state",     dbg_state, m_own);
    chk("one_grant", grant_x & grant_y, 0);
    if (bus_valid) chk("bus_owner", bus, grant_x ? x_data : y_data);
    if (grant_x && !prev_gx) chk("start_x_req", req_x, 1);
    if (grant_y && !prev_gy) chk("start_y_req", req_y, 1);
    prev_gx = grant_x;
    prev_gy = grant_y;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit rx, input bit ry,
                       input logic [W-1:0] dx, input logic [W-1:0] dy);
    rst    = r;
    req_x  = rx;
    req_y  = ry;
    x_data = dx;
    y_data = dy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit rx;
    bit ry;
    logic [W-1:0] dx;
    logic [W-1:0] dy;

    // 1: reset dominates requests.
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 1, 16'hAAAA, 16'h5555);
      chk("t1_valid", bus_valid, 0);
      chk("t1_sel", sel, 0);
    end

    // 2: lone X transfer for five cycles.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 16'h1234, 16'(i));
      chk("t2_grant_x", grant_x, 1);
      chk("t2_bus", bus, 16'h1234);
    end
    cycle(0, 0, 0, 16'h1234, 16'h0);
    chk("t2_drop", bus_valid, 0);

    // 3: tie goes to X, then Y without a bubble.
    cycle(1, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 16'h0A0A, 16'hB0B0);
      chk("t3_x_first", grant_x, 1);
    end
    cycle(0, 0, 1, 16'h0A0A, 16'hB0B0);
    chk("t3_y_next", grant_y, 1);
    chk("t3_bus_y", bus, 16'hB0B0);
    cycle(0, 0, 1, 16'h0A0A, 16'hB0B0);
    cycle(0, 0, 0, 16'h0A0A, 16'hB0B0);

    // 4: both held for 20 cycles.
    cycle(1, 0, 0, 16'h0, 16'h0);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 1, 16'h1111, 16'h2222);
      chk("t4_pattern", grant_x, TO_EN ? (((k / MH) % 2) == 0) : 1);
    end

    // 5: reset in the middle of a Y grant, then X wins the tie.
    cycle(1, 0, 0, 16'h0, 16'h0);
    cycle(0, 0, 1, 16'h3333, 16'h4444);
    cycle(0, 0, 1, 16'h3333, 16'h4444);
    chk("t5_in_y", grant_y, 1);
    cycle(1, 0, 1, 16'h3333, 16'h4444);
    chk("t5_rst_valid", bus_valid, 0);
    chk("t5_rst_sel", sel, 0);
    cycle(0, 1, 1, 16'h3333, 16'h4444);
    chk("t5_x_wins", grant_x, 1);
    cycle(0, 0, 0, 16'h3333, 16'h4444);

    // 6: randomized traffic; data only changes on the side not owning the bus.
    rx = 0; ry = 0; dx = 16'h0; dy = 16'h0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) rx = ~rx;
      if ($urandom_range(3) == 0) ry = ~ry;
      if (m_own != 1) dx = 16'($urandom);
      if (m_own != 2) dy = 16'($urandom);
      cycle(($urandom_range(99) == 0), rx, ry, dx, dy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_arbiter_2to1
